// File: rtl/lutram_stream_fifo.sv
// lutram_stream_fifo: first-word-fall-through ready/valid FIFO built on a
// distributed-RAM array with one synchronous write port and one asynchronous
// read port. Pointers carry an extra wrap bit so full and empty can be told
// apart without a separate state machine. Handshake flags are registered and
// computed from next-state pointers, so in_ready/out_valid never depend
// combinationally on in_valid or out_ready.

module lutram_stream_fifo_chk #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = DEPTH - 2,
  parameter int unsigned PW          = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          pop,
  input logic          in_ready,
  input logic          out_valid,
  input logic [PW-1:0] count,
  input logic          almost_full,
  input logic [PW-1:0] wr_ptr,
  input logic [PW-1:0] rd_ptr
);

  // Elaboration-time sanity on the geometry.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_bad
    $error("lutram_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_af_bad
    $error("lutram_stream_fifo: ALMOST_FULL must lie in 1..DEPTH");
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count < PW'(DEPTH)));
  a_ready_full : assert property (@(posedge clk) disable iff (!rst_n)
    (count == PW'(DEPTH)) |-> !in_ready);
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count != {PW{1'b0}}));
  a_valid_empty : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid == (count != {PW{1'b0}}));
  a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
    count <= PW'(DEPTH));
  a_almost_full : assert property (@(posedge clk) disable iff (!rst_n)
    almost_full == (count >= PW'(ALMOST_FULL)));
  a_count_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
    count == PW'(wr_ptr - rd_ptr));

endmodule

module lutram_stream_fifo #(
  parameter type         DATA_TYPE   = logic,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  DATA_TYPE                   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output DATA_TYPE                   out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Storage: intentionally not reset so it maps onto distributed RAM.
  DATA_TYPE mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          almost_full_q, almost_full_d;

  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  assign push_s   = in_valid & in_ready_q;
  assign pop_s    = out_valid_q & out_ready;
  assign wr_idx_s = wr_ptr_q[AW-1:0];
  assign rd_idx_s = rd_ptr_q[AW-1:0];

  // Next-state pointers, occupancy and handshake flags; flush wins over traffic.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    almost_full_d = almost_full_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + PW'(push_s) - PW'(pop_s);
    end
    // Full: same index, opposite wrap flag. Empty: identical pointers.
    in_ready_d    = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                      (wr_ptr_d[AW] != rd_ptr_d[AW]));
    out_valid_d   = (wr_ptr_d != rd_ptr_d);
    almost_full_d = (count_d >= PW'(ALMOST_FULL));
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {PW{1'b0}};
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage write port; a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wr_idx_s] <= in_data;
    end
  end

  assign out_data    = mem_q[rd_idx_s];
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign almost_full = almost_full_q;

  lutram_stream_fifo_chk #(
    .DEPTH       (DEPTH),
    .ALMOST_FULL (ALMOST_FULL),
    .PW          (PW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_s),
    .pop         (pop_s),
    .in_ready    (in_ready_q),
    .out_valid   (out_valid_q),
    .count       (count_q),
    .almost_full (almost_full_q),
    .wr_ptr      (wr_ptr_q),
    .rd_ptr      (rd_ptr_q)
  );

endmodule
